// File: rtl/regfile_pkg.sv
// ============================================================================
// Module : regfile_pkg
// Brief  : Shared register-file sizing defaults and the hardwired-zero index.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package regfile_pkg;
  localparam int DEF_XLEN       = 32;
  localparam int DEF_NREGS      = 32;
  localparam int DEF_LOG2_NREGS = $clog2(DEF_NREGS);
  localparam int ZERO_REG       = 0;
endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Round-robin arbiter; grants the first requester at or after rr_ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic             update_en,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  // Outer loop walks priority order from r_ptr; inner loop keeps indices constant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!w_found && req[j] && (j == ((int'(r_ptr) + k) % NREQ))) begin
          w_found   = 1'b1;
          grant[j]  = 1'b1;
          grant_idx = IDX_W'(j);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (update_en && w_found) begin
      r_ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
// ============================================================================
// Module : regfile_wb_arbiter
// Brief  : Round-robin writeback port sharing with a per-register busy scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int XLEN       = DEF_XLEN,
  parameter int NREGS      = DEF_NREGS,
  parameter int LOG2_NREGS = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ*LOG2_NREGS-1:0] req_addr,
  input  logic [NREQ*XLEN-1:0]       req_data,
  input  logic                       claim_valid,
  input  logic [LOG2_NREGS-1:0]      claim_addr,
  output logic [NREGS-1:0]           busy_mask,
  output logic                       claim_conflict,
  output logic                       write_enable,
  output logic [LOG2_NREGS-1:0]      write_addr,
  output logic [XLEN-1:0]            write_data,
  output logic [$clog2(NREQ)-1:0]    grant_id
);

  localparam int GID_W = $clog2(NREQ);
  localparam logic [LOG2_NREGS-1:0] c_zero_addr = LOG2_NREGS'(ZERO_REG);

  logic [NREQ-1:0]       w_req;
  logic [NREQ-1:0]       w_grant;
  logic [GID_W-1:0]      w_grant_idx;
  logic                  w_xfer;
  logic [LOG2_NREGS-1:0] w_addr_arr [NREQ];
  logic [XLEN-1:0]       w_data_arr [NREQ];
  logic [LOG2_NREGS-1:0] w_sel_addr;
  logic [XLEN-1:0]       w_sel_data;
  logic                  w_set;
  logic                  w_clr_hit;
  logic                  w_conflict;
  logic [NREGS-1:0]      w_busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign w_addr_arr[gi] = req_addr[gi*LOG2_NREGS +: LOG2_NREGS];
      assign w_data_arr[gi] = req_data[gi*XLEN +: XLEN];
    end
  endgenerate

  // Masking the request vector keeps ready low and the pointer frozen in reset.
  assign w_req = reset ? '0 : req_valid;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (GID_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .req       (w_req),
    .update_en (1'b1),
    .grant     (w_grant),
    .grant_idx (w_grant_idx)
  );

  assign req_ready  = w_grant;
  assign w_xfer     = |w_grant;
  assign w_sel_addr = w_addr_arr[w_grant_idx];
  assign w_sel_data = w_data_arr[w_grant_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      grant_id     <= '0;
    end else if (w_xfer) begin
      write_enable <= (w_sel_addr != c_zero_addr);
      write_addr   <= w_sel_addr;
      write_data   <= w_sel_data;
      grant_id     <= w_grant_idx;
    end else begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
    end
  end

  // Clear is applied before set so a fresh claim overrides a retiring write.
  always_comb begin
    w_set       = claim_valid && (claim_addr != c_zero_addr);
    w_clr_hit   = write_enable && (write_addr == claim_addr);
    w_conflict  = w_set && busy_mask[claim_addr] && !w_clr_hit;
    w_busy_next = busy_mask;
    if (write_enable) begin
      w_busy_next[write_addr] = 1'b0;
    end
    if (w_set) begin
      w_busy_next[claim_addr] = 1'b1;
    end
    w_busy_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_mask      <= '0;
      claim_conflict <= 1'b0;
    end else begin
      busy_mask      <= w_busy_next;
      claim_conflict <= w_conflict;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
// ============================================================================
// Module : tb_regfile_wb_arbiter
// Brief  : Directed self-checking bench for regfile_wb_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regfile_wb_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int NREGS = 32;
  localparam int LW = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [NREQ-1:0]  req_valid;
  logic [NREQ-1:0]  req_ready;
  logic [NREQ*LW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic             claim_valid;
  logic [LW-1:0]    claim_addr;
  logic [NREGS-1:0] busy_mask;
  logic             claim_conflict;
  logic             write_enable;
  logic [LW-1:0]    write_addr;
  logic [XLEN-1:0]  write_data;
  logic [0:0]       grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_wb_arbiter #(
    .NREQ(NREQ), .XLEN(XLEN), .NREGS(NREGS), .LOG2_NREGS(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data),
    .claim_valid(claim_valid), .claim_addr(claim_addr),
    .busy_mask(busy_mask), .claim_conflict(claim_conflict),
    .write_enable(write_enable), .write_addr(write_addr),
    .write_data(write_data), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = '0; req_addr = '0; req_data = '0;
    claim_valid = 1'b0; claim_addr = '0;
    tick(); tick();

    // Reset state
    check("rst_we", write_enable, 0);
    check("rst_busy", busy_mask, 0);
    check("rst_gid", grant_id, 0);
    check("rst_conflict", claim_conflict, 0);
    req_valid = 2'b11; #1;
    check("rst_ready_forced_low", req_ready, 0);
    req_valid = '0;
    reset = 1'b0;
    tick();

    // Single source
    claim_valid = 1'b1; claim_addr = 5'd5;
    tick();
    claim_valid = 1'b0;
    check("claim5_busy", busy_mask[5], 1);
    req_valid = 2'b01; req_addr[0 +: LW] = 5'd5; req_data[0 +: XLEN] = 32'hDEADBEEF;
    #1;
    check("single_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("single_we", write_enable, 1);
    check("single_addr", write_addr, 5);
    check("single_data", write_data, 32'hDEADBEEF);
    check("single_gid", grant_id, 0);
    check("single_busy_hold", busy_mask[5], 1);
    tick();
    check("single_busy_clr", busy_mask[5], 0);
    check("single_we_off", write_enable, 0);

    // Fairness from reset
    reset = 1'b1; tick(); reset = 1'b0;
    req_valid = 2'b11;
    req_addr[0 +: LW] = 5'd3;  req_addr[LW +: LW] = 5'd4;
    req_data[0 +: XLEN] = 32'hA0; req_data[XLEN +: XLEN] = 32'hB1;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("fair_ready%0d", k), req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      check($sformatf("fair_addr%0d", k), write_addr, (k % 2 == 0) ? 3 : 4);
      check($sformatf("fair_data%0d", k), write_data, (k % 2 == 0) ? 32'hA0 : 32'hB1);
      check($sformatf("fair_gid%0d", k), grant_id, k % 2);
    end
    req_valid = '0;
    tick();

    // Zero register
    req_valid = 2'b10; req_addr[LW +: LW] = 5'd0; req_data[XLEN +: XLEN] = 32'hFFFFFFFF;
    #1;
    check("zero_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    check("zero_we", write_enable, 0);
    claim_valid = 1'b1; claim_addr = 5'd0;
    tick();
    claim_valid = 1'b0;
    check("zero_claim_busy", busy_mask, 0);
    check("zero_claim_conflict", claim_conflict, 0);

    // Set beats clear
    claim_valid = 1'b1; claim_addr = 5'd7;
    tick();
    claim_valid = 1'b0;
    req_valid = 2'b01; req_addr[0 +: LW] = 5'd7; req_data[0 +: XLEN] = 32'h77;
    tick();
    req_valid = '0;
    check("sbc_we", write_enable, 1);
    claim_valid = 1'b1; claim_addr = 5'd7;
    tick();
    claim_valid = 1'b0;
    check("sbc_busy7", busy_mask[7], 1);
    check("sbc_conflict", claim_conflict, 0);

    // Double claim
    claim_valid = 1'b1; claim_addr = 5'd9;
    tick();
    check("dbl_first_conflict", claim_conflict, 0);
    tick();
    claim_valid = 1'b0;
    check("dbl_conflict", claim_conflict, 1);
    check("dbl_busy9", busy_mask[9], 1);
    tick();
    check("dbl_conflict_pulse", claim_conflict, 0);

    // Reset mid-operation
    req_valid = 2'b01; req_addr[0 +: LW] = 5'd2; req_data[0 +: XLEN] = 32'h22;
    #1;
    check("mid_ready", req_ready, 2'b01);
    tick();
    req_valid = '0; reset = 1'b1;
    tick();
    check("mid_we", write_enable, 0);
    check("mid_busy", busy_mask, 0);
    reset = 1'b0;
    req_valid = 2'b11;
    req_addr[0 +: LW] = 5'd3; req_addr[LW +: LW] = 5'd4;
    #1;
    check("mid_ptr_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    check("mid_ptr_addr", write_addr, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
